urisc_dpmem_responder: RTL and testbench
========================================

Name: urisc_dpmem_responder

Overview:
- Memory-side responder for the subleq core's dual-port instruction/data memory interface. Serves two independent request ports with a req/ack handshake and fixed 1-cycle read latency.
- After reset, sweeps and clears the whole array before accepting traffic.
- Resolves same-cycle write collisions and read-during-write hazards deterministically, and flags out-of-range accesses.
- Sits between the processor core and the storage array, replacing the bare memory.

Parameters:
- WORD_SIZE, gc::WORD_SIZE, width of data and address words.
- DEPTH, 256, number of words in the array; addresses >= DEPTH are out of range.
- MMIO_ADDR, DEPTH-1, address decoded as the output register when the optional feature is enabled.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- add1  input  WORD_SIZE  port 1 address.
- dataIn1  input  WORD_SIZE  port 1 write data.
- write1  input  1  port 1 write enable (qualified by req1).
- req1  input  1  port 1 request.
- dataOut1  output  WORD_SIZE  port 1 read data.
- ack1  output  1  port 1 response valid.
- add2, dataIn2, write2, req2, dataOut2, ack2: same as port 1, for port 2.
- busy  output  1  high while reset is asserted and during the clear sweep.
- collision  output  1  one-cycle pulse on a same-address dual write.
- err  output  1  one-cycle pulse on any out-of-range access.

Behaviour:
- Reset (rst=0, asynchronous) drives these values: dataOut1/2=0, ack1/2=0, collision=0, err=0, busy=1, sweep counter=0, state=CLEAR.
- State CLEAR:
  - Each cycle writes 0 to mem[sweep], then sweep+1.
  - After writing DEPTH-1, goes to READY on the next edge, with busy=0 from that edge.
  - Takes exactly DEPTH cycles after rst deasserts.
- Requests during CLEAR are ignored. No ack is produced and there are no side effects. Initiators wait for busy=0.
- State READY:
  - A request with req=1 sampled at edge N gets ack=1 at edge N+1, for exactly one cycle per accepted request.
  - Back-to-back requests give back-to-back acks.
- Read (write=0): dataOut = mem[add] as of the end of cycle N, with same-cycle writes applied first (write-first). dataOut holds its last value when ack=0.
- Write (write=1): mem[add] <= dataIn at edge N. dataOut echoes the written value with ack.
- Both ports write the same address in the same cycle: port 1 wins and port 2 data is dropped. Both ports are acked. collision=1 for one cycle, aligned with the acks.
- One port writes and the other reads the same address in the same cycle: the reader receives the new data.
- Out-of-range address (add >= DEPTH):
  - The write is discarded; a read returns 0.
  - The request is still acked, and err=1 aligned with that ack.
  - err is the OR of both ports.
- Reset mid-operation:
  - Pending acks are cancelled and outputs go to their reset values.
  - Array contents are undefined until the new CLEAR sweep completes.
- Width rules:
  - Address compare uses the full WORD_SIZE width; no truncation or wrap.
  - The sweep counter is sized to reach DEPTH-1 and must not wrap to re-enter CLEAR.

Optional Feature:
- Macro: URISC_MMIO_EN.
- With the macro defined:
  - Adds output port led [WORD_SIZE-1:0], reset to 0.
  - A write to MMIO_ADDR from either port updates led on the same edge as the array write (port 1 wins on collision), and also writes the array.
  - Reads of MMIO_ADDR return the array word.
- Without the macro: the led port is absent and MMIO_ADDR is an ordinary word.

Test Plan:
- Release rst, idle -> busy=1 for exactly 256 cycles then 0. Reads of addresses 0, 100 and 255 return 0 with ack one cycle after req.
- Port1 writes 0x1234 to addr 5 at edge N; port2 reads addr 5 at edge N -> ack2 at N+1 with dataOut2=0x1234.
- Same edge: port1 writes 0xAAAA to addr 7 and port2 writes 0x5555 to addr 7 -> collision pulse at N+1, and a later read of addr 7 returns 0xAAAA.
- Port2 reads addr 300 and port1 writes addr 256 -> both acked, err=1 for one cycle, dataOut2=0, and a subsequent read of addr 0 is unchanged.
- Write 0xBEEF to addr 9, assert rst mid-burst while acks are pending -> acks drop immediately and busy rises. After the 256-cycle sweep, addr 9 reads 0.
- With URISC_MMIO_EN: port2 writes 0x0042 to addr 255 -> led=0x0042 on that edge, and port1 reading addr 255 returns 0x0042.

Source files
------------

// File: rtl/urisc_dpmem_responder.sv
// Dual-port memory responder for the subleq core: clears the array after reset, then serves req/ack traffic.
// Optional URISC_MMIO_EN adds a led output register mapped at MMIO_ADDR.
package gc;
  localparam int WORD_SIZE = 16;
endpackage

module urisc_dpmem_responder #(
  parameter int WORD_SIZE = gc::WORD_SIZE,
  parameter int DEPTH     = 256,
  parameter int MMIO_ADDR = DEPTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] add1,
  input  logic [WORD_SIZE-1:0] dataIn1,
  input  logic                 write1,
  input  logic                 req1,
  output logic [WORD_SIZE-1:0] dataOut1,
  output logic                 ack1,
  input  logic [WORD_SIZE-1:0] add2,
  input  logic [WORD_SIZE-1:0] dataIn2,
  input  logic                 write2,
  input  logic                 req2,
  output logic [WORD_SIZE-1:0] dataOut2,
  output logic                 ack2,
  output logic                 busy,
  output logic                 collision,
  output logic                 err
`ifdef URISC_MMIO_EN
  ,
  output logic [WORD_SIZE-1:0] led
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state;
  logic [AW-1:0]        sweep;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 ok1, ok2, sameAdd, wr1, wr2, dualWr;
  logic [AW-1:0]        idx1, idx2;
  logic [WORD_SIZE-1:0] rd1, rd2;

  // Full-width range check; port 2's write is suppressed when port 1 writes the same word.
  always_comb begin
    ok1     = {1'b0, add1} < (WORD_SIZE+1)'(DEPTH);
    ok2     = {1'b0, add2} < (WORD_SIZE+1)'(DEPTH);
    idx1    = add1[AW-1:0];
    idx2    = add2[AW-1:0];
    sameAdd = (add1 == add2);
    dualWr  = req1 & write1 & req2 & write2 & sameAdd;
    wr1     = req1 & write1 & ok1;
    wr2     = req2 & write2 & ok2 & ~(wr1 & sameAdd);
    rd1     = '0;
    rd2     = '0;
    // Write-first: each port returns the word as it stands after this cycle's writes.
    if (ok1) rd1 = wr1 ? dataIn1 : (wr2 && sameAdd) ? dataIn2 : mem[idx1];
    if (ok2) rd2 = (wr1 && sameAdd) ? dataIn1 : wr2 ? dataIn2 : mem[idx2];
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[sweep] <= '0;
    end else begin
      if (wr1) mem[idx1] <= dataIn1;
      if (wr2) mem[idx2] <= dataIn2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      sweep     <= '0;
      busy      <= 1'b1;
      ack1      <= 1'b0;
      ack2      <= 1'b0;
      dataOut1  <= '0;
      dataOut2  <= '0;
      collision <= 1'b0;
      err       <= 1'b0;
`ifdef URISC_MMIO_EN
      led       <= '0;
`endif
    end else if (state == CLEAR) begin
      ack1      <= 1'b0;
      ack2      <= 1'b0;
      collision <= 1'b0;
      err       <= 1'b0;
      // Hold the counter at the last word so the sweep never re-enters.
      if (sweep == AW'(DEPTH - 1)) begin
        state <= READY;
        busy  <= 1'b0;
      end else begin
        sweep <= sweep + 1'b1;
      end
    end else begin
      ack1      <= req1;
      ack2      <= req2;
      collision <= dualWr;
      err       <= (req1 & ~ok1) | (req2 & ~ok2);
      if (req1) dataOut1 <= rd1;
      if (req2) dataOut2 <= rd2;
`ifdef URISC_MMIO_EN
      if (wr1 && add1 == WORD_SIZE'(MMIO_ADDR))      led <= dataIn1;
      else if (wr2 && add2 == WORD_SIZE'(MMIO_ADDR)) led <= dataIn2;
`endif
    end
  end

`ifndef URISC_MMIO_EN
  logic unusedMmio;
  assign unusedMmio = (MMIO_ADDR == 0);
`endif
endmodule

// File: tb/tb_urisc_dpmem_responder.sv
// Bench for urisc_dpmem_responder: per-cycle reference model plus directed literal checks.
module tb_urisc_dpmem_responder;
  localparam int W     = gc::WORD_SIZE;
  localparam int DEPTH = 256;

  logic         clk = 1'b0, rst = 1'b0;
  logic [W-1:0] add1 = '0, dataIn1 = '0, add2 = '0, dataIn2 = '0;
  logic         write1 = 1'b0, req1 = 1'b0, write2 = 1'b0, req2 = 1'b0;
  logic [W-1:0] dataOut1, dataOut2;
  logic         ack1, ack2, busy, collision, err;
`ifdef URISC_MMIO_EN
  logic [W-1:0] led;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  urisc_dpmem_responder #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .add1(add1), .dataIn1(dataIn1), .write1(write1), .req1(req1),
    .dataOut1(dataOut1), .ack1(ack1),
    .add2(add2), .dataIn2(dataIn2), .write2(write2), .req2(req2),
    .dataOut2(dataOut2), .ack2(ack2),
    .busy(busy), .collision(collision), .err(err)
`ifdef URISC_MMIO_EN
    , .led(led)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply port 2's write then port 1's (so port 1 wins), then read back.
  int           mm [DEPTH];
  int           sweepLeft, a1, a2;
  bit           in1, in2, w1, w2;
  logic [W-1:0] eD1, eD2;
  logic         eA1, eA2, eBusy, eCol, eErr;

  always @(posedge clk) begin
    if (!rst) begin
      foreach (mm[i]) mm[i] = 0;
      sweepLeft = DEPTH;
      eD1 = '0; eD2 = '0; eA1 = 0; eA2 = 0; eBusy = 1; eCol = 0; eErr = 0;
    end else if (sweepLeft > 0) begin
      sweepLeft--;
      eA1 = 0; eA2 = 0; eCol = 0; eErr = 0;
      eBusy = (sweepLeft != 0);
    end else begin
      a1 = int'(add1); a2 = int'(add2);
      in1 = a1 < DEPTH; in2 = a2 < DEPTH;
      w1 = req1 && write1; w2 = req2 && write2;
      if (w2 && in2) mm[a2] = int'(dataIn2);
      if (w1 && in1) mm[a1] = int'(dataIn1);
      if (req1) eD1 = in1 ? W'(mm[a1]) : '0;
      if (req2) eD2 = in2 ? W'(mm[a2]) : '0;
      eA1 = req1; eA2 = req2;
      eCol = w1 && w2 && (a1 == a2);
      eErr = (req1 && !in1) || (req2 && !in2);
    end
    #1;
    check("cyc ack1", ack1, eA1);
    check("cyc ack2", ack2, eA2);
    check("cyc busy", busy, eBusy);
    check("cyc collision", collision, eCol);
    check("cyc err", err, eErr);
    check("cyc dataOut1", dataOut1, eD1);
    check("cyc dataOut2", dataOut2, eD2);
  end

  task automatic cyc(input logic r1, input logic wr1, input logic [W-1:0] ad1, input logic [W-1:0] d1,
                     input logic r2, input logic wr2, input logic [W-1:0] ad2, input logic [W-1:0] d2);
    @(negedge clk);
    req1 = r1; write1 = wr1; add1 = ad1; dataIn1 = d1;
    req2 = r2; write2 = wr2; add2 = ad2; dataIn2 = d2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Counts edges from reset release until busy falls; bounded.
  task automatic sweepWait(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (busy && n < 400);
    check(name, n, 256);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1);
    check("reset ack1", ack1, 0);
    check("reset ack2", ack2, 0);
    check("reset dataOut1", dataOut1, 0);
    check("reset err", err, 0);

    // Requests held during the sweep must be ignored.
    @(negedge clk);
    req1 = 1; write1 = 1; add1 = 16'd3; dataIn1 = 16'hFFFF;
    req2 = 1; write2 = 0; add2 = 16'd3;
    rst = 1;
    sweepWait("clear sweep length");

    cyc(1, 0, 16'd0, '0, 1, 0, 16'd100, '0);
    check("rd0 ack1", ack1, 1);
    check("rd0 data", dataOut1, 0);
    check("rd100 data", dataOut2, 0);
    cyc(1, 0, 16'd255, '0, 1, 0, 16'd3, '0);
    check("rd255 data", dataOut1, 0);
    check("ignored clear write", dataOut2, 0);

    cyc(1, 1, 16'd5, 16'h1234, 1, 0, 16'd5, '0);
    check("rdw ack2", ack2, 1);
    check("rdw data", dataOut2, 16'h1234);

    cyc(1, 1, 16'd7, 16'hAAAA, 1, 1, 16'd7, 16'h5555);
    check("collision pulse", collision, 1);
    cyc(1, 0, 16'd7, '0, 0, 0, '0, '0);
    check("collision winner", dataOut1, 16'hAAAA);
    check("collision drop", collision, 0);

    cyc(1, 1, 16'd256, 16'h7777, 1, 0, 16'd300, '0);
    check("oor err", err, 1);
    check("oor ack1", ack1, 1);
    check("oor ack2", ack2, 1);
    check("oor read", dataOut2, 0);
    cyc(1, 0, 16'd0, '0, 1, 0, 16'd5, '0);
    check("oor no wrap", dataOut1, 0);
    check("oor err clear", err, 0);
    check("addr5 kept", dataOut2, 16'h1234);

    cyc(1, 1, 16'd20, 16'h0101, 0, 0, '0, '0);
    cyc(1, 0, 16'd20, '0, 0, 0, '0, '0);
    check("b2b ack", ack1, 1);
    check("b2b data", dataOut1, 16'h0101);
    idle();
    check("idle ack", ack1, 0);
    check("idle hold", dataOut1, 16'h0101);

    cyc(1, 1, 16'd9, 16'hBEEF, 1, 0, 16'd9, '0);
    check("beef echo", dataOut2, 16'hBEEF);
    @(negedge clk);
    req1 = 1; write1 = 0; add1 = 16'd9; req2 = 0;
    rst = 0;
    #1;
    check("midrst ack1", ack1, 0);
    check("midrst busy", busy, 1);
    check("midrst data", dataOut2, 0);
    repeat (3) @(negedge clk);
    req1 = 0; rst = 1;
    sweepWait("resweep length");
    cyc(1, 0, 16'd9, '0, 0, 0, '0, '0);
    check("resweep addr9", dataOut1, 0);

`ifdef URISC_MMIO_EN
    cyc(0, 0, '0, '0, 1, 1, 16'd255, 16'h0042);
    check("mmio led", led, 16'h0042);
    cyc(1, 0, 16'd255, '0, 0, 0, '0, '0);
    check("mmio readback", dataOut1, 16'h0042);
`endif

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
